// File: rtl/dbus_ctrl_pkg.sv
// dbus_ctrl_pkg: shared FSM/slave types and the default data-side address map
package dbus_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SLV_NONE, SLV_DMEM, SLV_TIMER, SLV_TBMAN} slv_t;
  localparam logic [31:0] DMEM_BASE_DEF  = 32'h1000_0000;
  localparam logic [31:0] DMEM_MASK_DEF  = 32'hFFFF_0000;
  localparam logic [31:0] TIMER_BASE_DEF = 32'hFFFF_8000;
  localparam logic [31:0] TIMER_MASK_DEF = 32'hFFFF_FF00;
  localparam logic [31:0] TBMAN_BASE_DEF = 32'hFFFF_F000;
  localparam logic [31:0] TBMAN_MASK_DEF = 32'hFFFF_FF00;
endpackage

// File: rtl/dbus_ctrl_if.sv
// dbus_ctrl_if: CPU load/store handshake plus the shared slave bus
// master: CPU/slave side (drives request fields and slave read data)
// slave:  controller side (drives response, latched bus and chip selects)
interface dbus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_we;
  logic        cs_dmem_n;
  logic        cs_timer_n;
  logic        cs_tbman_n;
  logic [31:0] rdata_dmem;
  logic [31:0] rdata_timer;
  logic [31:0] rdata_tbman;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, rdata_dmem, rdata_timer, rdata_tbman,
    input  cpu_rdata, cpu_ready, cpu_err, bus_addr, bus_wdata, bus_be, bus_we,
           cs_dmem_n, cs_timer_n, cs_tbman_n
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, rdata_dmem, rdata_timer, rdata_tbman,
    output cpu_rdata, cpu_ready, cpu_err, bus_addr, bus_wdata, bus_be, bus_we,
           cs_dmem_n, cs_timer_n, cs_tbman_n
  );
endinterface

// File: rtl/dbus_ctrl_decode.sv
// dbus_ctrl_decode: combinational address -> slave decode, DMEM > timer > TBMAN on overlap
// addr in, slv out (SLV_NONE when unmapped)
module dbus_ctrl_decode import dbus_ctrl_pkg::*; #(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_MASK  = DMEM_MASK_DEF,
  parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEF,
  parameter logic [31:0] TIMER_MASK = TIMER_MASK_DEF,
  parameter logic [31:0] TBMAN_BASE = TBMAN_BASE_DEF,
  parameter logic [31:0] TBMAN_MASK = TBMAN_MASK_DEF
) (
  input  logic [31:0] addr,
  output slv_t        slv
);
  always_comb slv = ~|((addr ^ DMEM_BASE) & DMEM_MASK)   ? SLV_DMEM  :
                    ~|((addr ^ TIMER_BASE) & TIMER_MASK) ? SLV_TIMER :
                    ~|((addr ^ TBMAN_BASE) & TBMAN_MASK) ? SLV_TBMAN : SLV_NONE;
endmodule

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: data-bus controller, one outstanding access, per-slave wait states, registered response
// clk, reset_n (sync, active low); bus: dbus_ctrl_if.slave (CPU handshake, slave bus, chip selects)
module dbus_ctrl import dbus_ctrl_pkg::*; #(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_MASK  = DMEM_MASK_DEF,
  parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEF,
  parameter logic [31:0] TIMER_MASK = TIMER_MASK_DEF,
  parameter logic [31:0] TBMAN_BASE = TBMAN_BASE_DEF,
  parameter logic [31:0] TBMAN_MASK = TBMAN_MASK_DEF,
  parameter int unsigned WS_DMEM    = 0,
  parameter int unsigned WS_TIMER   = 1,
  parameter int unsigned WS_TBMAN   = 1
) (
  input logic        clk,
  input logic        reset_n,
  dbus_ctrl_if.slave bus
);
  if (WS_DMEM > 15 || WS_TIMER > 15 || WS_TBMAN > 15) begin : g_ws_check
    $error("dbus_ctrl: wait states must be within 0..15");
  end
  state_t      st;
  slv_t        dec;
  slv_t        slv;
  logic        we;
  logic [3:0]  cnt;
  logic [3:0]  ws;
  logic [31:0] rdata_sel;
  dbus_ctrl_decode #(
    .DMEM_BASE(DMEM_BASE), .DMEM_MASK(DMEM_MASK),
    .TIMER_BASE(TIMER_BASE), .TIMER_MASK(TIMER_MASK),
    .TBMAN_BASE(TBMAN_BASE), .TBMAN_MASK(TBMAN_MASK)
  ) u_decode (
    .addr(bus.cpu_addr),
    .slv (dec)
  );
  always_comb ws = dec == SLV_DMEM ? 4'(WS_DMEM) : dec == SLV_TIMER ? 4'(WS_TIMER) : 4'(WS_TBMAN);
  always_comb rdata_sel = slv == SLV_DMEM  ? bus.rdata_dmem  :
                          slv == SLV_TIMER ? bus.rdata_timer : bus.rdata_tbman;
  // bus_we is registered one edge ahead so it is high exactly in the final select cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st             <= IDLE;
      slv            <= SLV_NONE;
      we             <= 1'b0;
      cnt            <= 4'd0;
      bus.cs_dmem_n  <= 1'b1;
      bus.cs_timer_n <= 1'b1;
      bus.cs_tbman_n <= 1'b1;
      bus.bus_we     <= 1'b0;
      bus.cpu_ready  <= 1'b0;
      bus.cpu_err    <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.bus_addr   <= '0;
      bus.bus_wdata  <= '0;
      bus.bus_be     <= '0;
    end else begin
      case (st)
        IDLE: if (bus.cpu_req) begin
          bus.bus_addr  <= bus.cpu_addr;
          bus.bus_wdata <= bus.cpu_wdata;
          bus.bus_be    <= bus.cpu_be;
          we            <= bus.cpu_we;
          slv           <= dec;
          cnt           <= ws;
          if (dec == SLV_NONE) begin
            st            <= RESP;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
          end else begin
            st             <= ACCESS;
            bus.cs_dmem_n  <= dec != SLV_DMEM;
            bus.cs_timer_n <= dec != SLV_TIMER;
            bus.cs_tbman_n <= dec != SLV_TBMAN;
            bus.bus_we     <= bus.cpu_we && ws == 4'd0;
          end
        end
        ACCESS: if (cnt == 4'd0) begin
          st             <= RESP;
          bus.cs_dmem_n  <= 1'b1;
          bus.cs_timer_n <= 1'b1;
          bus.cs_tbman_n <= 1'b1;
          bus.bus_we     <= 1'b0;
          bus.cpu_ready  <= 1'b1;
          bus.cpu_rdata  <= we ? '0 : rdata_sel;
        end else begin
          cnt        <= cnt - 4'd1;
          bus.bus_we <= we && cnt == 4'd1;
        end
        default: begin
          st            <= IDLE;
          bus.cpu_ready <= 1'b0;
          bus.cpu_err   <= 1'b0;
          bus.cpu_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl: randomized and directed checks of dbus_ctrl against an address-range reference model
module tb_dbus_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  dbus_ctrl_if bif();
  dbus_ctrl_if bov();
  dbus_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bif));
  dbus_ctrl #(.TIMER_BASE(32'h1000_0000)) dut_ov (.clk(clk), .reset_n(reset_n), .bus(bov));

  // reference map from plain address ranges: 1=DMEM 2=timer 3=TBMAN 0=unmapped
  function automatic int region(input logic [31:0] a);
    if (a >= 32'h1000_0000 && a < 32'h1001_0000) return 1;
    if (a >= 32'hFFFF_8000 && a < 32'hFFFF_8100) return 2;
    if (a >= 32'hFFFF_F000 && a < 32'hFFFF_F100) return 3;
    return 0;
  endfunction

  function automatic int waits(input int r);
    return r == 1 ? 0 : 1;
  endfunction

  // issues one access at a negedge in IDLE and follows it cycle by cycle to the next IDLE cycle
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] rd_d, input logic [31:0] rd_t, input logic [31:0] rd_b,
                        input bit hold);
    int r;
    int n;
    logic [31:0] rd [4];
    logic [2:0] cs_exp;
    r = region(a);
    rd[0] = 32'h0; rd[1] = rd_d; rd[2] = rd_t; rd[3] = rd_b;
    bif.rdata_dmem = rd_d; bif.rdata_timer = rd_t; bif.rdata_tbman = rd_b;
    bif.cpu_req = 1'b1; bif.cpu_we = w; bif.cpu_addr = a; bif.cpu_wdata = wd; bif.cpu_be = be;
    @(negedge clk);
    if (hold) begin
      bif.cpu_we = $urandom_range(0, 1); bif.cpu_addr = $urandom; bif.cpu_wdata = $urandom; bif.cpu_be = 4'($urandom);
    end else bif.cpu_req = 1'b0;
    if (r == 0) begin
      tests++; if (bif.cpu_ready !== 1'b1) begin fails++; $display("FAIL unmapped_ready addr=%h got %b want 1", a, bif.cpu_ready); end
      tests++; if (bif.cpu_err !== 1'b1) begin fails++; $display("FAIL unmapped_err addr=%h got %b want 1", a, bif.cpu_err); end
      tests++; if (bif.cpu_rdata !== 32'h0) begin fails++; $display("FAIL unmapped_rdata addr=%h got %h want 0", a, bif.cpu_rdata); end
      tests++; if ({bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n} !== 3'b111 || bif.bus_we !== 1'b0) begin
        fails++; $display("FAIL unmapped_cs addr=%h got cs=%b we=%b want cs=111 we=0", a, {bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n}, bif.bus_we);
      end
    end else begin
      n = waits(r) + 1;
      cs_exp = ~(3'b001 << (r - 1));
      for (int k = 1; k <= n; k++) begin
        tests++; if ({bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n} !== cs_exp) begin
          fails++; $display("FAIL access_cs addr=%h cyc=%0d got %b want %b", a, k, {bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n}, cs_exp);
        end
        tests++; if (bif.bus_we !== (w && k == n)) begin
          fails++; $display("FAIL access_we addr=%h cyc=%0d got %b want %b", a, k, bif.bus_we, w && k == n);
        end
        tests++; if (bif.bus_addr !== a || bif.bus_wdata !== wd || bif.bus_be !== be) begin
          fails++; $display("FAIL access_bus cyc=%0d got %h/%h/%h want %h/%h/%h", k, bif.bus_addr, bif.bus_wdata, bif.bus_be, a, wd, be);
        end
        tests++; if (bif.cpu_ready !== 1'b0) begin fails++; $display("FAIL access_early_ready addr=%h cyc=%0d got 1 want 0", a, k); end
        @(negedge clk);
      end
      tests++; if (bif.cpu_ready !== 1'b1 || bif.cpu_err !== 1'b0) begin
        fails++; $display("FAIL resp_ready_err addr=%h got %b/%b want 1/0", a, bif.cpu_ready, bif.cpu_err);
      end
      tests++; if (bif.cpu_rdata !== (w ? 32'h0 : rd[r])) begin
        fails++; $display("FAIL resp_rdata addr=%h got %h want %h", a, bif.cpu_rdata, w ? 32'h0 : rd[r]);
      end
      tests++; if ({bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n} !== 3'b111 || bif.bus_we !== 1'b0) begin
        fails++; $display("FAIL resp_cs addr=%h got cs=%b we=%b want 111/0", a, {bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n}, bif.bus_we);
      end
    end
    @(negedge clk);
    tests++; if (bif.cpu_ready !== 1'b0 || bif.cpu_err !== 1'b0 || {bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n} !== 3'b111) begin
      fails++; $display("FAIL idle_after_resp addr=%h got rdy=%b err=%b cs=%b want 0/0/111", a, bif.cpu_ready, bif.cpu_err, {bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n});
    end
  endtask

  task automatic test_reset();
    bif.cpu_req = 1'b1; bif.cpu_addr = 32'h1000_0000;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n} !== 3'b111) begin fails++; $display("FAIL reset_cs got %b want 111", {bif.cs_tbman_n, bif.cs_timer_n, bif.cs_dmem_n}); end
    tests++; if (bif.cpu_ready !== 1'b0 || bif.cpu_err !== 1'b0 || bif.bus_we !== 1'b0) begin
      fails++; $display("FAIL reset_flags got rdy=%b err=%b we=%b want 0/0/0", bif.cpu_ready, bif.cpu_err, bif.bus_we);
    end
    tests++; if (bif.cpu_rdata !== 32'h0 || bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0 || bif.bus_be !== 4'h0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h/%h want zeros", bif.cpu_rdata, bif.bus_addr, bif.bus_wdata, bif.bus_be);
    end
    bif.cpu_req = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dmem_read();
    access(32'h1000_0010, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 1'b0);
  endtask

  task automatic test_timer_write();
    access(32'hFFFF_8004, 1'b1, 32'h0000_00A5, 4'b0001, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555, 1'b0);
  endtask

  task automatic test_unmapped();
    access(32'h2000_0000, 1'b0, 32'h0, 4'hF, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 1'b0);
  endtask

  task automatic test_back_to_back();
    access(32'hFFFF_F000, 1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 32'hCAFE_0001, 1'b1);
    access(32'h1000_0000, 1'b0, 32'h0, 4'hF, 32'hCAFE_0002, 32'h0, 32'h0, 1'b1);
    bif.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    logic [31:0] tbl [8];
    tbl = '{32'h0FFF_FFFF, 32'h1000_FFFF, 32'h1001_0000, 32'hFFFF_7FFF,
            32'hFFFF_80FF, 32'hFFFF_8100, 32'hFFFF_F0FF, 32'hFFFF_F100};
    for (int i = 0; i < 8; i++) access(tbl[i], 1'b0, 32'h0, 4'hF, $urandom, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b1; bif.cpu_addr = 32'hFFFF_8004; bif.cpu_wdata = 32'hA5; bif.cpu_be = 4'b0001;
    @(negedge clk);
    bif.cpu_req = 1'b0;
    tests++; if (bif.cs_timer_n !== 1'b0) begin fails++; $display("FAIL midrst_cs_before got %b want 0", bif.cs_timer_n); end
    reset_n = 1'b0;
    @(negedge clk);
    tests++; if (bif.cs_timer_n !== 1'b1 || bif.bus_we !== 1'b0 || bif.cpu_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_abort got cs=%b we=%b rdy=%b want 1/0/0", bif.cs_timer_n, bif.bus_we, bif.cpu_ready);
    end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bif.cpu_ready !== 1'b0 || bif.bus_we !== 1'b0 || bif.cs_timer_n !== 1'b1) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst_quiet got activity after reset want none"); end
    access(32'h1000_0100, 1'b0, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_overlap();
    bov.rdata_dmem = 32'h1234_5678; bov.rdata_timer = 32'h8765_4321; bov.rdata_tbman = 32'h0;
    bov.cpu_req = 1'b1; bov.cpu_we = 1'b0; bov.cpu_addr = 32'h1000_0000; bov.cpu_be = 4'hF;
    @(negedge clk);
    bov.cpu_req = 1'b0;
    tests++; if (bov.cs_dmem_n !== 1'b0 || bov.cs_timer_n !== 1'b1 || bov.cs_tbman_n !== 1'b1) begin
      fails++; $display("FAIL overlap_cs got %b%b%b want 110", bov.cs_tbman_n, bov.cs_timer_n, bov.cs_dmem_n);
    end
    @(negedge clk);
    tests++; if (bov.cpu_ready !== 1'b1 || bov.cpu_rdata !== 32'h1234_5678) begin
      fails++; $display("FAIL overlap_resp got rdy=%b rdata=%h want 1/12345678", bov.cpu_ready, bov.cpu_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'h1000_0000 + 32'($urandom_range(0, 32'hFFFF));
        2: a = 32'hFFFF_8000 + 32'($urandom_range(0, 255));
        default: a = 32'hFFFF_F000 + 32'($urandom_range(0, 255));
      endcase
      access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom, $urandom, bit'($urandom_range(0, 1)));
    end
    bif.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_addr = '0; bif.cpu_wdata = '0; bif.cpu_be = '0;
    bif.rdata_dmem = '0; bif.rdata_timer = '0; bif.rdata_tbman = '0;
    bov.cpu_req = 1'b0; bov.cpu_we = 1'b0; bov.cpu_addr = '0; bov.cpu_wdata = '0; bov.cpu_be = '0;
    bov.rdata_dmem = '0; bov.rdata_timer = '0; bov.rdata_tbman = '0;
    test_reset();
    test_dmem_read();
    test_timer_write();
    test_unmapped();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    test_overlap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
